// File: rtl/c_fetch_ctrl.sv
// RV32IC fetch sequencer: word fetches, parcel split, straddle reassembly.
// One instruction per decode handshake, branch redirect with in-flight drop.
module c_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic              inst_is_c_o,
    output logic              pc_misaligned_o,
    output logic              stall_pc_o
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DRAIN
    } state_e;

    localparam logic [ADDR_W-1:0] WMASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] TWO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] FOUR  = ADDR_W'(4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic              off_q, off_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic [15:0]       hbuf_q, hbuf_d;
    logic [ADDR_W-1:0] hbuf_pc_q, hbuf_pc_d;
    logic              hbuf_v_q, hbuf_v_d;

    logic [15:0] parcel;
    logic        par_c;
    logic        valid;
    logic        fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            faddr_q   <= RESET_PC & WMASK;
            off_q     <= RESET_PC[1];
            wbuf_q    <= '0;
            hbuf_q    <= '0;
            hbuf_pc_q <= '0;
            hbuf_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            faddr_q   <= faddr_d;
            off_q     <= off_d;
            wbuf_q    <= wbuf_d;
            hbuf_q    <= hbuf_d;
            hbuf_pc_q <= hbuf_pc_d;
            hbuf_v_q  <= hbuf_v_d;
        end
    end

    assign parcel = off_q ? wbuf_q[31:16] : wbuf_q[15:0];
    assign par_c  = parcel[1:0] != 2'b11;
    // Upper-half 32-bit parcel without a buffered low half is not issuable.
    assign valid  = (state_q == S_ISSUE) && (hbuf_v_q || par_c || !off_q);
    assign fire   = valid && inst_ready_i;

    always_comb begin
        state_d   = state_q;
        faddr_d   = faddr_q;
        off_d     = off_q;
        wbuf_d    = wbuf_q;
        hbuf_d    = hbuf_q;
        hbuf_pc_d = hbuf_pc_q;
        hbuf_v_d  = hbuf_v_q;
        unique case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    wbuf_d  = imem_rdata_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hbuf_v_q) begin
                    if (fire) begin
                        hbuf_v_d = 1'b0;
                        off_d    = 1'b1;
                    end
                end else if (par_c && !off_q) begin
                    if (fire) off_d = 1'b1;
                end else if (par_c || !off_q) begin
                    if (fire) begin
                        faddr_d = faddr_q + FOUR;
                        off_d   = 1'b0;
                        state_d = S_FETCH;
                    end
                end else begin
                    hbuf_d    = parcel;
                    hbuf_pc_d = faddr_q + TWO;
                    hbuf_v_d  = 1'b1;
                    faddr_d   = faddr_q + FOUR;
                    off_d     = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid_i) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (br_taken_i) begin
            hbuf_v_d = 1'b0;
            faddr_d  = br_target_i & WMASK;
            off_d    = br_target_i[1];
            // A request still in flight must be absorbed before refetching.
            if (state_q == S_FETCH ||
                ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid_i))
                state_d = S_DRAIN;
            else
                state_d = S_FETCH;
        end
    end

    assign imem_req_o      = (state_q == S_FETCH) && !reset;
    assign imem_addr_o     = imem_req_o ? faddr_q : '0;
    assign inst_valid_o    = valid;
    assign inst_o          = !valid   ? 32'h0 :
                             hbuf_v_q ? {wbuf_q[15:0], hbuf_q} :
                             par_c    ? {16'h0, parcel} : wbuf_q;
    assign inst_pc_o       = !valid   ? '0 :
                             hbuf_v_q ? hbuf_pc_q :
                             faddr_q + ADDR_W'({off_q, 1'b0});
    assign inst_is_c_o     = valid && !hbuf_v_q && par_c;
    assign pc_misaligned_o = valid && hbuf_v_q;
    assign stall_pc_o      = !(valid && inst_ready_i);

endmodule
